// File: rtl/atm_pkg.sv
// ---------------------------------------------------------------------------
// atm_pkg
// Shared types and widths for the ATM transaction controller.
//   STATE_W : width of the controller state encoding
//   NOTE_W  : width of the selected / remaining note counter
//   state_e : controller states, encoded 0..6 in the order below
// ---------------------------------------------------------------------------
package atm_pkg;

    localparam int STATE_W = 3;
    localparam int NOTE_W  = 4;

    typedef enum logic [STATE_W-1:0] {
        IDLE     = 3'd0,
        PIN      = 3'd1,
        AMOUNT   = 3'd2,
        CHECK    = 3'd3,
        DISPENSE = 3'd4,
        DONE     = 3'd5,
        LOCKED   = 3'd6
    } state_e;

endpackage

// File: rtl/atm_btn_edge.sv
// ---------------------------------------------------------------------------
// atm_btn_edge
// Turns a raw button level into a single-cycle pulse, one cycle after the
// rising edge of the level.
//   clk     : system clock
//   rst     : synchronous active-high reset
//   level_i : raw (already debounced) button level
//   pulse_o : one-cycle pulse per rising edge of level_i
// ---------------------------------------------------------------------------
module atm_btn_edge (
    input  logic clk,
    input  logic rst,
    input  logic level_i,
    output logic pulse_o
);

    logic prev_q;
    logic pulse_q;

    // Remember last cycle's level and register the rising-edge detect so the
    // controller always sees a clean, glitch-free pulse from a flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            prev_q  <= level_i;
            pulse_q <= level_i & ~prev_q;
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/atm_txn_ctrl.sv
// ---------------------------------------------------------------------------
// atm_txn_ctrl
// Transaction sequencer for the ATM: PIN check, note-count selection from the
// front-panel buttons, balance check, then one note per dispenser handshake.
// Owns the account balance.
//   clk, rst    : system clock, synchronous active-high reset
//   card_in     : level, card present
//   pin_code    : PIN value, sampled while pin_valid is high
//   pin_valid   : one-cycle strobe qualifying pin_code
//   btn_up/down : raw levels, +1 / -1 note
//   btn_ok      : raw level, confirm selection
//   btn_cancel  : raw level, abort transaction
//   disp_ready  : dispenser accepts a note this cycle
//   disp_pulse  : one note issued this cycle
//   notes_o     : selected / remaining note count
//   balance_o   : current balance
//   state_o     : controller state encoding (debug / display)
//   pin_err_o   : one-cycle pulse on a wrong PIN
//   insuf_o     : one-cycle pulse when the balance cannot cover the request
//   locked_o    : level, card lock-out active
//   done_o      : one-cycle pulse on the first cycle of a completed withdrawal
// ---------------------------------------------------------------------------
module atm_txn_ctrl
    import atm_pkg::*;
#(
    parameter int unsigned BAL_W        = 16,
    parameter int unsigned NOTE_VAL     = 100,
    parameter int unsigned MAX_NOTES    = 10,
    parameter int unsigned INIT_BALANCE = 1000,
    parameter logic [15:0] PIN_CODE     = 16'h1234,
    parameter int unsigned MAX_TRIES    = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               card_in,
    input  logic [15:0]        pin_code,
    input  logic               pin_valid,
    input  logic               btn_up,
    input  logic               btn_down,
    input  logic               btn_ok,
    input  logic               btn_cancel,
    input  logic               disp_ready,
    output logic               disp_pulse,
    output logic [NOTE_W-1:0]  notes_o,
    output logic [BAL_W-1:0]   balance_o,
    output logic [STATE_W-1:0] state_o,
    output logic               pin_err_o,
    output logic               insuf_o,
    output logic               locked_o,
    output logic               done_o
);

    localparam int unsigned TRY_W  = $clog2(MAX_TRIES + 1);
    localparam int unsigned PROD_W = BAL_W + NOTE_W;

    localparam logic [BAL_W-1:0]  NOTE_VAL_B  = BAL_W'(NOTE_VAL);
    localparam logic [PROD_W-1:0] NOTE_VAL_P  = PROD_W'(NOTE_VAL);
    localparam logic [BAL_W-1:0]  INIT_BAL_B  = BAL_W'(INIT_BALANCE);
    localparam logic [NOTE_W-1:0] MAX_NOTES_N = NOTE_W'(MAX_NOTES);
    localparam logic [TRY_W-1:0]  MAX_TRIES_T = TRY_W'(MAX_TRIES);

    logic upPulse;
    logic downPulse;
    logic okPulse;
    logic cancelPulse;

    state_e             state_q,   state_d;
    logic [NOTE_W-1:0]  notes_q,   notes_d;
    logic [BAL_W-1:0]   balance_q, balance_d;
    logic [TRY_W-1:0]   tries_q,   tries_d;
    logic               done_q,    done_d;

    logic               pinErr;
    logic               insuf;
    logic               dispPulse;
    logic               abortReq;
    logic [TRY_W-1:0]   triesInc;
    logic [PROD_W-1:0]  requestAmt;

    atm_btn_edge u_edge_up     (.clk(clk), .rst(rst), .level_i(btn_up),     .pulse_o(upPulse));
    atm_btn_edge u_edge_down   (.clk(clk), .rst(rst), .level_i(btn_down),   .pulse_o(downPulse));
    atm_btn_edge u_edge_ok     (.clk(clk), .rst(rst), .level_i(btn_ok),     .pulse_o(okPulse));
    atm_btn_edge u_edge_cancel (.clk(clk), .rst(rst), .level_i(btn_cancel), .pulse_o(cancelPulse));

    // Cancel or card removal aborts any transaction not yet committed to
    // dispensing; the request is widened so notes*NOTE_VAL cannot wrap.
    assign abortReq   = cancelPulse | ~card_in;
    assign triesInc   = tries_q + TRY_W'(1);
    assign requestAmt = PROD_W'(notes_q) * NOTE_VAL_P;

    // State and datapath registers; reset restores the opening balance too,
    // so a reset mid-transaction discards any partial withdrawal.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            notes_q   <= '0;
            balance_q <= INIT_BAL_B;
            tries_q   <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            notes_q   <= notes_d;
            balance_q <= balance_d;
            tries_q   <= tries_d;
            done_q    <= done_d;
        end
    end

    // Next-state, datapath update and the event pulses. Abort has priority
    // in PIN/AMOUNT/CHECK; in AMOUNT an accepted ok wins over up/down, and a
    // simultaneous up+down cancels out. DISPENSE deliberately ignores abort.
    always_comb begin
        state_d   = state_q;
        notes_d   = notes_q;
        balance_d = balance_q;
        tries_d   = tries_q;
        done_d    = 1'b0;
        pinErr    = 1'b0;
        insuf     = 1'b0;
        dispPulse = 1'b0;

        case (state_q)
            IDLE: begin
                if (card_in) begin
                    state_d = PIN;
                end
            end

            PIN: begin
                if (abortReq) begin
                    state_d = IDLE;
                    notes_d = '0;
                end else if (pin_valid) begin
                    if (pin_code == PIN_CODE) begin
                        state_d = AMOUNT;
                        tries_d = '0;
                    end else begin
                        pinErr  = 1'b1;
                        tries_d = triesInc;
                        if (triesInc >= MAX_TRIES_T) begin
                            state_d = LOCKED;
                        end
                    end
                end
            end

            AMOUNT: begin
                if (abortReq) begin
                    state_d = IDLE;
                    notes_d = '0;
                end else if (okPulse && (notes_q != '0)) begin
                    state_d = CHECK;
                end else if (upPulse && !downPulse) begin
                    if (notes_q < MAX_NOTES_N) begin
                        notes_d = notes_q + NOTE_W'(1);
                    end
                end else if (downPulse && !upPulse) begin
                    if (notes_q != '0) begin
                        notes_d = notes_q - NOTE_W'(1);
                    end
                end
            end

            CHECK: begin
                if (abortReq) begin
                    state_d = IDLE;
                    notes_d = '0;
                end else if (requestAmt <= PROD_W'(balance_q)) begin
                    state_d = DISPENSE;
                end else begin
                    insuf   = 1'b1;
                    notes_d = '0;
                    state_d = AMOUNT;
                end
            end

            DISPENSE: begin
                if (disp_ready) begin
                    dispPulse = 1'b1;
                    balance_d = balance_q - NOTE_VAL_B;
                    notes_d   = notes_q - NOTE_W'(1);
                    if (notes_q == NOTE_W'(1)) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                end
            end

            DONE: begin
                if (!card_in) begin
                    state_d = IDLE;
                end
            end

            LOCKED: begin
                state_d = LOCKED;
            end

            default: begin
                state_d = IDLE;
                notes_d = '0;
            end
        endcase
    end

    assign disp_pulse = dispPulse;
    assign notes_o    = notes_q;
    assign balance_o  = balance_q;
    assign state_o    = state_q;
    assign pin_err_o  = pinErr;
    assign insuf_o    = insuf;
    assign locked_o   = (state_q == LOCKED);
    assign done_o     = done_q;

endmodule

// File: tb/tb_atm_txn_ctrl.sv
// ---------------------------------------------------------------------------
// tb_atm_txn_ctrl
// Self-checking bench for atm_txn_ctrl. Expected values come from a small
// account model (balance, note arithmetic, clamping) kept in the bench.
// ---------------------------------------------------------------------------
module tb_atm_txn_ctrl;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_PIN      = 3'd1;
    localparam logic [2:0] ST_AMOUNT   = 3'd2;
    localparam logic [2:0] ST_CHECK    = 3'd3;
    localparam logic [2:0] ST_DISPENSE = 3'd4;
    localparam logic [2:0] ST_DONE     = 3'd5;
    localparam logic [2:0] ST_LOCKED   = 3'd6;
    localparam int NOTE  = 100;
    localparam int START = 1000;

    logic        clk = 1'b0;
    logic        rst;
    logic        card_in;
    logic [15:0] pin_code;
    logic        pin_valid;
    logic        btn_up;
    logic        btn_down;
    logic        btn_ok;
    logic        btn_cancel;
    logic        disp_ready;
    logic        disp_pulse;
    logic [3:0]  notes_o;
    logic [15:0] balance_o;
    logic [2:0]  state_o;
    logic        pin_err_o;
    logic        insuf_o;
    logic        locked_o;
    logic        done_o;

    int checks = 0;
    int errors = 0;
    int pulseCnt = 0;
    int doneCnt = 0;
    int pinErrCnt = 0;
    int insufCnt = 0;
    int mBalance = START;

    atm_txn_ctrl dut (
        .clk(clk), .rst(rst), .card_in(card_in), .pin_code(pin_code),
        .pin_valid(pin_valid), .btn_up(btn_up), .btn_down(btn_down),
        .btn_ok(btn_ok), .btn_cancel(btn_cancel), .disp_ready(disp_ready),
        .disp_pulse(disp_pulse), .notes_o(notes_o), .balance_o(balance_o),
        .state_o(state_o), .pin_err_o(pin_err_o), .insuf_o(insuf_o),
        .locked_o(locked_o), .done_o(done_o)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    // Count event pulses as they are seen at each active edge
    always @(posedge clk) begin
        if (disp_pulse === 1'b1) pulseCnt++;
        if (done_o === 1'b1) doneCnt++;
        if (pin_err_o === 1'b1) pinErrCnt++;
        if (insuf_o === 1'b1) insufCnt++;
    end

    // Hard time limit so the bench can never hang
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Press one button for one cycle and wait until the controller has acted
    task automatic press(input int which);
        case (which)
            0: btn_up = 1'b1;
            1: btn_down = 1'b1;
            2: btn_ok = 1'b1;
            default: btn_cancel = 1'b1;
        endcase
        @(negedge clk);
        btn_up = 1'b0; btn_down = 1'b0; btn_ok = 1'b0; btn_cancel = 1'b0;
        @(negedge clk);
    endtask

    task automatic enter_pin(input logic [15:0] code, output logic errSeen);
        pin_code = code;
        pin_valid = 1'b1;
        #1 errSeen = pin_err_o;
        @(negedge clk);
        pin_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; card_in = 1'b0; pin_valid = 1'b0; pin_code = 16'h0;
        btn_up = 1'b0; btn_down = 1'b0; btn_ok = 1'b0; btn_cancel = 1'b0;
        disp_ready = 1'b0;
        cyc(2);
        rst = 1'b0;
        cyc(1);
        mBalance = START;
    endtask

    // Insert card and enter the correct PIN; ends in AMOUNT
    task automatic open_session();
        logic err;
        card_in = 1'b1;
        cyc(1);
        enter_pin(16'h1234, err);
    endtask

    task automatic run_dispense(input int budget, input bit randomReady, output bit reached);
        reached = 1'b0;
        for (int i = 0; i < budget && !reached; i++) begin
            disp_ready = randomReady ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (state_o === ST_DONE) reached = 1'b1;
        end
        disp_ready = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (state_o !== ST_IDLE) begin errors++; $display("[TB] FAIL reset_state: got %0d want %0d", state_o, ST_IDLE); end
        checks++; if (notes_o !== 4'd0) begin errors++; $display("[TB] FAIL reset_notes: got %0d want 0", notes_o); end
        checks++; if (balance_o !== 16'(START)) begin errors++; $display("[TB] FAIL reset_balance: got %0d want %0d", balance_o, START); end
        checks++; if ({disp_pulse, pin_err_o, insuf_o, locked_o, done_o} !== 5'b0) begin
            errors++; $display("[TB] FAIL reset_flags: got %b want 00000", {disp_pulse, pin_err_o, insuf_o, locked_o, done_o});
        end
    endtask

    task automatic test_basic_withdraw();
        logic err;
        bit reached;
        int p0, d0;
        card_in = 1'b1;
        cyc(1);
        checks++; if (state_o !== ST_PIN) begin errors++; $display("[TB] FAIL card_to_pin: got %0d want %0d", state_o, ST_PIN); end
        enter_pin(16'h1234, err);
        checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL good_pin_err: got %b want 0", err); end
        checks++; if (state_o !== ST_AMOUNT) begin errors++; $display("[TB] FAIL pin_to_amount: got %0d want %0d", state_o, ST_AMOUNT); end
        repeat (3) press(0);
        checks++; if (notes_o !== 4'd3) begin errors++; $display("[TB] FAIL select_3: got %0d want 3", notes_o); end
        p0 = pulseCnt; d0 = doneCnt;
        press(2);
        checks++; if (state_o !== ST_CHECK) begin errors++; $display("[TB] FAIL ok_to_check: got %0d want %0d", state_o, ST_CHECK); end
        cyc(1);
        checks++; if (state_o !== ST_DISPENSE) begin errors++; $display("[TB] FAIL check_one_cycle: got %0d want %0d", state_o, ST_DISPENSE); end
        run_dispense(20, 1'b0, reached);
        checks++; if (!reached) begin errors++; $display("[TB] FAIL basic_done_reached: got 0 want 1"); end
        checks++; if (done_o !== 1'b1) begin errors++; $display("[TB] FAIL basic_done_pulse: got %b want 1", done_o); end
        mBalance -= 3 * NOTE;
        checks++; if (balance_o !== 16'(mBalance)) begin errors++; $display("[TB] FAIL basic_balance: got %0d want %0d", balance_o, mBalance); end
        card_in = 1'b0;
        cyc(2);
        checks++; if (pulseCnt - p0 !== 3) begin errors++; $display("[TB] FAIL basic_pulses: got %0d want 3", pulseCnt - p0); end
        checks++; if (doneCnt - d0 !== 1) begin errors++; $display("[TB] FAIL basic_done_count: got %0d want 1", doneCnt - d0); end
        checks++; if (state_o !== ST_IDLE) begin errors++; $display("[TB] FAIL done_to_idle: got %0d want %0d", state_o, ST_IDLE); end
    endtask

    task automatic test_saturation();
        int mNotes = 0;
        int i0;
        open_session();
        for (int i = 0; i < 12; i++) begin press(0); mNotes = (mNotes + 1 > 10) ? 10 : mNotes + 1; end
        checks++; if (notes_o !== 4'(mNotes)) begin errors++; $display("[TB] FAIL up_saturate: got %0d want %0d", notes_o, mNotes); end
        for (int i = 0; i < 12; i++) begin press(1); mNotes = (mNotes - 1 < 0) ? 0 : mNotes - 1; end
        checks++; if (notes_o !== 4'(mNotes)) begin errors++; $display("[TB] FAIL down_saturate: got %0d want %0d", notes_o, mNotes); end
        i0 = insufCnt;
        press(2);
        cyc(1);
        checks++; if (state_o !== ST_AMOUNT) begin errors++; $display("[TB] FAIL ok_at_zero: got %0d want %0d", state_o, ST_AMOUNT); end
        checks++; if (insufCnt !== i0) begin errors++; $display("[TB] FAIL ok_at_zero_insuf: got %0d want %0d", insufCnt, i0); end
        press(3);
        card_in = 1'b0;
        cyc(1);
    endtask

    task automatic test_cancel();
        open_session();
        repeat (5) press(0);
        checks++; if (notes_o !== 4'd5) begin errors++; $display("[TB] FAIL cancel_select: got %0d want 5", notes_o); end
        press(3);
        checks++; if (state_o !== ST_IDLE) begin errors++; $display("[TB] FAIL cancel_state: got %0d want %0d", state_o, ST_IDLE); end
        checks++; if (notes_o !== 4'd0) begin errors++; $display("[TB] FAIL cancel_notes: got %0d want 0", notes_o); end
        checks++; if (balance_o !== 16'(mBalance)) begin errors++; $display("[TB] FAIL cancel_balance: got %0d want %0d", balance_o, mBalance); end
        card_in = 1'b0;
        cyc(1);
    endtask

    task automatic test_ready_toggle();
        bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        int d0;
        open_session();
        repeat (2) press(0);
        press(2);
        cyc(1);
        d0 = doneCnt;
        card_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            disp_ready = pat[i];
            #1;
            checks++; if (disp_pulse !== pat[i]) begin errors++; $display("[TB] FAIL toggle_pulse_%0d: got %b want %b", i, disp_pulse, pat[i]); end
            @(negedge clk);
        end
        disp_ready = 1'b0;
        mBalance -= 2 * NOTE;
        checks++; if (state_o !== ST_DONE) begin errors++; $display("[TB] FAIL toggle_done: got %0d want %0d", state_o, ST_DONE); end
        checks++; if (balance_o !== 16'(mBalance)) begin errors++; $display("[TB] FAIL toggle_balance: got %0d want %0d", balance_o, mBalance); end
        cyc(2);
        checks++; if (doneCnt - d0 !== 1) begin errors++; $display("[TB] FAIL toggle_done_count: got %0d want 1", doneCnt - d0); end
        checks++; if (state_o !== ST_IDLE) begin errors++; $display("[TB] FAIL toggle_idle: got %0d want %0d", state_o, ST_IDLE); end
    endtask

    task automatic test_insufficient();
        bit reached;
        int i0;
        do_reset();
        open_session();
        repeat (10) press(0);
        press(2);
        run_dispense(200, 1'b1, reached);
        checks++; if (!reached) begin errors++; $display("[TB] FAIL full_withdraw_done: got 0 want 1"); end
        mBalance -= 10 * NOTE;
        checks++; if (balance_o !== 16'(mBalance)) begin errors++; $display("[TB] FAIL full_withdraw_balance: got %0d want %0d", balance_o, mBalance); end
        card_in = 1'b0;
        cyc(1);
        open_session();
        repeat (10) press(0);
        i0 = insufCnt;
        press(2);
        #1;
        checks++; if (insuf_o !== 1'b1) begin errors++; $display("[TB] FAIL insuf_pulse: got %b want 1", insuf_o); end
        cyc(1);
        checks++; if (state_o !== ST_AMOUNT) begin errors++; $display("[TB] FAIL insuf_state: got %0d want %0d", state_o, ST_AMOUNT); end
        checks++; if (notes_o !== 4'd0) begin errors++; $display("[TB] FAIL insuf_notes: got %0d want 0", notes_o); end
        checks++; if (insufCnt - i0 !== 1) begin errors++; $display("[TB] FAIL insuf_count: got %0d want 1", insufCnt - i0); end
        press(3);
        card_in = 1'b0;
        cyc(1);
    endtask

    task automatic test_random();
        bit reached;
        int mNotes, p0, i0, len;
        logic [2:0] expState;
        do_reset();
        for (int it = 0; it < 12; it++) begin
            open_session();
            mNotes = 0;
            len = $urandom_range(1, 14);
            for (int k = 0; k < len; k++) begin
                if ($urandom_range(0, 9) < 7) begin press(0); mNotes = (mNotes >= 10) ? 10 : mNotes + 1; end
                else begin press(1); mNotes = (mNotes <= 0) ? 0 : mNotes - 1; end
            end
            if (mNotes == 0) begin press(0); mNotes = 1; end
            checks++; if (notes_o !== 4'(mNotes)) begin errors++; $display("[TB] FAIL rand_notes_%0d: got %0d want %0d", it, notes_o, mNotes); end
            p0 = pulseCnt; i0 = insufCnt;
            press(2);
            cyc(1);
            expState = (mNotes * NOTE <= mBalance) ? ST_DISPENSE : ST_AMOUNT;
            checks++; if (state_o !== expState) begin errors++; $display("[TB] FAIL rand_check_%0d: got %0d want %0d", it, state_o, expState); end
            if (expState == ST_DISPENSE) begin
                run_dispense(300, 1'b1, reached);
                mBalance -= mNotes * NOTE;
                checks++; if (pulseCnt - p0 !== mNotes) begin errors++; $display("[TB] FAIL rand_pulses_%0d: got %0d want %0d", it, pulseCnt - p0, mNotes); end
                checks++; if (balance_o !== 16'(mBalance)) begin errors++; $display("[TB] FAIL rand_balance_%0d: got %0d want %0d", it, balance_o, mBalance); end
            end else begin
                checks++; if (insufCnt - i0 !== 1) begin errors++; $display("[TB] FAIL rand_insuf_%0d: got %0d want 1", it, insufCnt - i0); end
                press(3);
            end
            card_in = 1'b0;
            cyc(2);
            if (mBalance < 200) do_reset();
        end
    endtask

    task automatic test_reset_mid_dispense();
        do_reset();
        open_session();
        repeat (4) press(0);
        press(2);
        cyc(1);
        disp_ready = 1'b1;
        cyc(2);
        checks++; if (balance_o !== 16'(mBalance - 2 * NOTE)) begin errors++; $display("[TB] FAIL mid_dispense_balance: got %0d want %0d", balance_o, mBalance - 2 * NOTE); end
        rst = 1'b1; card_in = 1'b0; disp_ready = 1'b0;
        cyc(1);
        rst = 1'b0;
        cyc(1);
        mBalance = START;
        checks++; if (balance_o !== 16'(START)) begin errors++; $display("[TB] FAIL rst_mid_balance: got %0d want %0d", balance_o, START); end
        checks++; if (state_o !== ST_IDLE || notes_o !== 4'd0) begin errors++; $display("[TB] FAIL rst_mid_state: got state %0d notes %0d want 0 0", state_o, notes_o); end
    endtask

    task automatic test_wrong_pin();
        logic err;
        int e0;
        card_in = 1'b1;
        cyc(1);
        e0 = pinErrCnt;
        for (int i = 0; i < 3; i++) begin
            enter_pin(16'h0000, err);
            checks++; if (err !== 1'b1) begin errors++; $display("[TB] FAIL pin_err_%0d: got %b want 1", i, err); end
            if (i == 1) begin
                checks++; if (locked_o !== 1'b0) begin errors++; $display("[TB] FAIL early_lock: got %b want 0", locked_o); end
            end
        end
        checks++; if (pinErrCnt - e0 !== 3) begin errors++; $display("[TB] FAIL pin_err_count: got %0d want 3", pinErrCnt - e0); end
        checks++; if (locked_o !== 1'b1 || state_o !== ST_LOCKED) begin errors++; $display("[TB] FAIL locked: got %b/%0d want 1/%0d", locked_o, state_o, ST_LOCKED); end
        card_in = 1'b0;
        cyc(3);
        card_in = 1'b1;
        enter_pin(16'h1234, err);
        cyc(3);
        checks++; if (state_o !== ST_LOCKED) begin errors++; $display("[TB] FAIL lock_holds: got %0d want %0d", state_o, ST_LOCKED); end
        do_reset();
        checks++; if (locked_o !== 1'b0) begin errors++; $display("[TB] FAIL unlock_by_rst: got %b want 0", locked_o); end
    endtask

    initial begin
        test_reset();
        test_basic_withdraw();
        test_saturation();
        test_cancel();
        test_ready_toggle();
        test_insufficient();
        test_random();
        test_reset_mid_dispense();
        test_wrong_pin();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
